// File: rtl/tmds_pkg.sv
// Shared TMDS definitions: word geometry, the four control tokens, decoded-word
// payload and the receive alignment states.
package tmds_pkg;

  localparam int unsigned WORD_W = 10;
  localparam int unsigned DATA_W = 8;

  localparam logic [WORD_W-1:0] TOKEN_00 = 10'b1101010100;
  localparam logic [WORD_W-1:0] TOKEN_01 = 10'b0010101011;
  localparam logic [WORD_W-1:0] TOKEN_10 = 10'b0101010100;
  localparam logic [WORD_W-1:0] TOKEN_11 = 10'b1010101011;

  typedef enum logic {
    SEARCH = 1'b0,
    LOCKED = 1'b1
  } tmds_state_e;

  typedef struct packed {
    logic              de;
    logic              c1;
    logic              c0;
    logic [DATA_W-1:0] data;
  } tmds_dec_t;

endpackage

// File: rtl/tmds_word_decode.sv
// Combinational 10b word decode: control-token lookup, else undo the
// optional inversion and the XOR/XNOR transition chain.
module tmds_word_decode
  import tmds_pkg::*;
(
  input  logic [WORD_W-1:0] q_i,
  output tmds_dec_t         dec_c_o
);

  logic [DATA_W-1:0] d_c;

  always_comb begin
    dec_c_o = '0;
    d_c     = q_i[9] ? ~q_i[7:0] : q_i[7:0];
    unique case (q_i)
      TOKEN_00: {dec_c_o.c1, dec_c_o.c0} = 2'b00;
      TOKEN_01: {dec_c_o.c1, dec_c_o.c0} = 2'b01;
      TOKEN_10: {dec_c_o.c1, dec_c_o.c0} = 2'b10;
      TOKEN_11: {dec_c_o.c1, dec_c_o.c0} = 2'b11;
      default: begin
        dec_c_o.de      = 1'b1;
        dec_c_o.data[0] = d_c[0];
        for (int i = 1; i < int'(DATA_W); i++) begin
          dec_c_o.data[i] = q_i[8] ? (d_c[i] ^ d_c[i-1]) : ~(d_c[i] ^ d_c[i-1]);
        end
      end
    endcase
  end

endmodule

// File: rtl/tmds_channel_decoder.sv
// One TMDS channel receiver: deserialise at bit rate, hunt word alignment on
// control tokens, decode and present one word per 10 clocks with a strobe.
module tmds_channel_decoder
  import tmds_pkg::*;
#(
  parameter int unsigned LOCK_COUNT = 8,
  parameter int unsigned LOSS_WORDS = 4096
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              din,
  output logic              pixel_strobe,
  output logic [DATA_W-1:0] data,
  output logic              c0,
  output logic              c1,
  output logic              de,
  output logic              locked
);

  localparam int unsigned CNT_W   = 4;
  localparam int unsigned MATCH_W = $clog2(LOCK_COUNT + 1);
  localparam int unsigned MISS_W  = $clog2(LOSS_WORDS + 1);
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WORD_W - 1);

  logic [WORD_W-1:1]  sr_q, sr_d;
  logic [CNT_W-1:0]   bit_cnt_q, bit_cnt_d;
  logic               slip_q, slip_d;
  tmds_state_e        state_q, state_d;
  logic [MATCH_W-1:0] match_q, match_d;
  logic [MISS_W-1:0]  miss_q, miss_d;
  logic               vld1_q, vld1_d, emit1_q, emit1_d;
  tmds_dec_t          dec1_q, dec1_d;
  logic               vld2_q, emit2_q;
  tmds_dec_t          dec2_q;
  logic               strobe_q, strobe_d, locked_q, locked_d;
  logic               de_q, de_d, c0_q, c0_d, c1_q, c1_d;
  logic [DATA_W-1:0]  data_q, data_d;

  logic [WORD_W-1:0]  word_c;
  logic               capture_c;
  logic               slip_req_c;
  tmds_dec_t          dec_c;

  assign word_c    = {din, sr_q};
  assign capture_c = (bit_cnt_q == LAST_BIT) && !slip_q;

  tmds_word_decode u_decode (
    .q_i     (word_c),
    .dec_c_o (dec_c)
  );

  always_comb begin
    sr_d       = word_c[WORD_W-1:1];
    bit_cnt_d  = CNT_W'(bit_cnt_q + CNT_W'(1));
    slip_d     = slip_q;
    state_d    = state_q;
    match_d    = match_q;
    miss_d     = miss_q;
    slip_req_c = 1'b0;
    vld1_d     = capture_c;
    emit1_d    = 1'b0;
    dec1_d     = dec_c;
    strobe_d   = 1'b0;
    locked_d   = locked_q;
    de_d       = de_q;
    data_d     = data_q;
    c0_d       = c0_q;
    c1_d       = c1_q;

    // Alignment FSM advances once per captured word.
    if (capture_c) begin
      unique case (state_q)
        SEARCH: begin
          if (!dec_c.de) begin
            if ((32'(match_q) + 32'd1) >= LOCK_COUNT) begin
              state_d = LOCKED;
              match_d = '0;
              miss_d  = '0;
            end else begin
              match_d = MATCH_W'(match_q + MATCH_W'(1));
            end
          end else begin
            match_d    = '0;
            slip_req_c = 1'b1;
          end
        end
        LOCKED: begin
          if (!dec_c.de) begin
            miss_d = '0;
          end else if ((32'(miss_q) + 32'd1) >= LOSS_WORDS) begin
            state_d = SEARCH;
            miss_d  = '0;
            match_d = '0;
          end else begin
            miss_d = MISS_W'(miss_q + MISS_W'(1));
          end
        end
      endcase
      emit1_d = (state_d == LOCKED);
    end

    // A slip parks the counter on the last bit for one extra clock.
    if (bit_cnt_q == LAST_BIT) begin
      if (slip_q) begin
        slip_d    = 1'b0;
        bit_cnt_d = '0;
      end else if (slip_req_c) begin
        slip_d    = 1'b1;
        bit_cnt_d = LAST_BIT;
      end else begin
        bit_cnt_d = '0;
      end
    end

    if (vld2_q) begin
      strobe_d = emit2_q;
      locked_d = emit2_q;
      if (emit2_q) begin
        de_d   = dec2_q.de;
        data_d = dec2_q.data;
        if (!dec2_q.de) begin
          c1_d = dec2_q.c1;
          c0_d = dec2_q.c0;
        end
      end else begin
        de_d   = 1'b0;
        data_d = '0;
        c0_d   = 1'b0;
        c1_d   = 1'b0;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sr_q      <= '0;
      bit_cnt_q <= '0;
      slip_q    <= 1'b0;
      state_q   <= SEARCH;
      match_q   <= '0;
      miss_q    <= '0;
      vld1_q    <= 1'b0;
      emit1_q   <= 1'b0;
      dec1_q    <= '0;
      vld2_q    <= 1'b0;
      emit2_q   <= 1'b0;
      dec2_q    <= '0;
      strobe_q  <= 1'b0;
      locked_q  <= 1'b0;
      de_q      <= 1'b0;
      data_q    <= '0;
      c0_q      <= 1'b0;
      c1_q      <= 1'b0;
    end else begin
      sr_q      <= sr_d;
      bit_cnt_q <= bit_cnt_d;
      slip_q    <= slip_d;
      state_q   <= state_d;
      match_q   <= match_d;
      miss_q    <= miss_d;
      vld1_q    <= vld1_d;
      emit1_q   <= emit1_d;
      dec1_q    <= dec1_d;
      vld2_q    <= vld1_q;
      emit2_q   <= emit1_q;
      dec2_q    <= dec1_q;
      strobe_q  <= strobe_d;
      locked_q  <= locked_d;
      de_q      <= de_d;
      data_q    <= data_d;
      c0_q      <= c0_d;
      c1_q      <= c1_d;
    end
  end

  assign pixel_strobe = strobe_q;
  assign locked       = locked_q;
  assign de           = de_q;
  assign data         = data_q;
  assign c0           = c0_q;
  assign c1           = c1_q;

endmodule
